// File: rtl/hold_press_detector.sv
// Multi-channel button front end: synchroniser, debouncer and short/long/held press classifier.
// Define HOLD_PRESS_AUTOREPEAT_EN to enable auto-repeat pulses on repeat_o while a channel is HELD.
module hold_press_detector #(
    parameter int N_CH            = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 5,
    parameter int REPEAT_CYCLES   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_i,
    input  logic [N_CH-1:0] ch_en_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] short_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] held_o,
    output logic [N_CH-1:0] repeat_o,
    output logic            any_held_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  H_LAST  = HW'(HOLD_CYCLES - 1);

    if (N_CH < 1 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("hold_press_detector: all parameters must be >= 1");
    end

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] held_nx;

    // Synchroniser ignores ch_en_i so a re-enabled channel sees the current pin level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_i;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic           d_q, d_nx;
        logic [DBW-1:0] db_cnt_q, db_cnt_nx;
        state_t         state_q, state_nx;
        logic [HW-1:0]  hcnt_q, hcnt_nx;
        logic           short_q, short_nx;
        logic           long_q, long_nx;

        always_comb begin
            d_nx      = d_q;
            db_cnt_nx = db_cnt_q;
            if (!ch_en_i[i]) begin
                d_nx      = 1'b0;
                db_cnt_nx = '0;
            end else if (sync2[i] == d_q) begin
                db_cnt_nx = '0;
            end else if (db_cnt_q == DB_LAST) begin
                d_nx      = sync2[i];
                db_cnt_nx = '0;
            end else begin
                db_cnt_nx = db_cnt_q + 1'b1;
            end
        end

        always_comb begin
            state_nx = state_q;
            hcnt_nx  = hcnt_q;
            short_nx = 1'b0;
            long_nx  = 1'b0;
            if (!ch_en_i[i]) begin
                state_nx = ST_IDLE;
                hcnt_nx  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (d_q) begin
                            state_nx = ST_PRESSED;
                            hcnt_nx  = '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (!d_q) begin
                            state_nx = ST_IDLE;
                            short_nx = 1'b1;
                        end else if (hcnt_q == H_LAST) begin
                            state_nx = ST_HELD;
                            long_nx  = 1'b1;
                        end else begin
                            hcnt_nx = hcnt_q + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!d_q) state_nx = ST_IDLE;
                    end
                    default: state_nx = ST_IDLE;
                endcase
            end
        end

        assign held_nx[i] = (state_nx == ST_HELD);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q      <= 1'b0;
                db_cnt_q <= '0;
                state_q  <= ST_IDLE;
                hcnt_q   <= '0;
                short_q  <= 1'b0;
                long_q   <= 1'b0;
            end else begin
                d_q      <= d_nx;
                db_cnt_q <= db_cnt_nx;
                state_q  <= state_nx;
                hcnt_q   <= hcnt_nx;
                short_q  <= short_nx;
                long_q   <= long_nx;
            end
        end

        assign level_o[i] = d_q;
        assign short_o[i] = short_q;
        assign long_o[i]  = long_q;
        assign held_o[i]  = (state_q == ST_HELD);

`ifdef HOLD_PRESS_AUTOREPEAT_EN
        localparam int RW = $clog2(REPEAT_CYCLES + 1);
        localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

        logic [RW-1:0] rcnt_q, rcnt_nx;
        logic          rep_q, rep_nx;

        // Counts only while staying in HELD; any other path leaves rcnt at zero.
        always_comb begin
            rcnt_nx = '0;
            rep_nx  = 1'b0;
            if (ch_en_i[i] && state_q == ST_HELD && d_q) begin
                if (rcnt_q == R_LAST) begin
                    rep_nx = 1'b1;
                end else begin
                    rcnt_nx = rcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt_q <= '0;
                rep_q  <= 1'b0;
            end else begin
                rcnt_q <= rcnt_nx;
                rep_q  <= rep_nx;
            end
        end

        assign repeat_o[i] = rep_q;
`else
        assign repeat_o[i] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) any_held_o <= 1'b0;
        else        any_held_o <= |held_nx;
    end

endmodule
